// File: rtl/supermic_pkg.sv
// rtl/supermic_pkg.sv - shared CIC/PCM widths, types and the PCM saturation helper
package supermic_pkg;

  localparam int PCM_W        = 19;
  localparam int CIC_ORDER    = 3;
  localparam int CIC_DEC_RATE = 64;
  localparam int CIC_ACC_W    = 20;

  typedef logic signed [PCM_W-1:0]     pcm_t;
  typedef logic signed [CIC_ACC_W-1:0] acc_t;

  localparam acc_t PCM_MAX = acc_t'((2 ** (PCM_W - 1)) - 1);
  localparam acc_t PCM_MIN = acc_t'(-(2 ** (PCM_W - 1)));

  function automatic pcm_t sat_pcm(input acc_t x);
    if (x > PCM_MAX) return pcm_t'(PCM_MAX[PCM_W-1:0]);
    if (x < PCM_MIN) return pcm_t'(PCM_MIN[PCM_W-1:0]);
    return pcm_t'(x[PCM_W-1:0]);
  endfunction

endpackage

// File: rtl/cic_channel.sv
// rtl/cic_channel.sv - one CIC channel: integrators, comb pipeline, saturated PCM result
module cic_channel
  import supermic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic                    sample_bit,
  input  logic                    dec_event,
  output logic signed [PCM_W-1:0] pcm_sat
);

  acc_t                 integ_q [CIC_ORDER];
  acc_t                 integ_d [CIC_ORDER];
  acc_t                 st_q    [CIC_ORDER-1];
  acc_t                 st_d    [CIC_ORDER-1];
  acc_t                 dly_q   [CIC_ORDER];
  acc_t                 dly_d   [CIC_ORDER];
  acc_t                 cap_q, cap_d;
  logic [CIC_ORDER-1:0] pipe_q, pipe_d;
  acc_t                 x;
  acc_t                 last_diff;

  always_comb begin
    x       = sample_bit ? acc_t'(1) : acc_t'(-1);
    integ_d = integ_q;
    if (sample_en) begin
      integ_d[0] = integ_q[0] + x;
      for (int i = 1; i < CIC_ORDER; i++) integ_d[i] = integ_q[i] + integ_q[i-1];
    end
    cap_d  = dec_event ? integ_q[CIC_ORDER-1] : cap_q;
    pipe_d = {pipe_q[CIC_ORDER-2:0], dec_event};
    // each comb stage advances only when the decimation event reaches it
    st_d  = st_q;
    dly_d = dly_q;
    if (pipe_q[0]) begin
      dly_d[0] = cap_q;
      st_d[0]  = cap_q - dly_q[0];
    end
    for (int j = 1; j < CIC_ORDER - 1; j++) begin
      if (pipe_q[j]) begin
        dly_d[j] = st_q[j-1];
        st_d[j]  = st_q[j-1] - dly_q[j];
      end
    end
    if (pipe_q[CIC_ORDER-1]) dly_d[CIC_ORDER-1] = st_q[CIC_ORDER-2];
    last_diff = st_q[CIC_ORDER-2] - dly_q[CIC_ORDER-1];
    pcm_sat   = sat_pcm(last_diff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        integ_q[i] <= '0;
        dly_q[i]   <= '0;
      end
      for (int i = 0; i < CIC_ORDER - 1; i++) st_q[i] <= '0;
      cap_q  <= '0;
      pipe_q <= '0;
    end else begin
      integ_q <= integ_d;
      dly_q   <= dly_d;
      st_q    <= st_d;
      cap_q   <= cap_d;
      pipe_q  <= pipe_d;
    end
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - PDM clock gen, sampling strobes and CIC R=64 decimation to PCM
// Optional second channel on the falling-phase slot: PDM_STEREO_EN.
module pdm_cic_decimator
  import supermic_pkg::*;
#(
  parameter int CLK_DIV  = 32,
  parameter int DEC_RATE = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    pdm_clk,
  input  logic                    pdm_in,
  output logic signed [PCM_W-1:0] pcm_data,
  output logic signed [PCM_W-1:0] pcm_data_b,
  output logic                    pcm_valid
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int DEC_W  = $clog2(DEC_RATE);
  localparam int WARM_W = $clog2(CIC_ORDER + 1);

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 pdm_clk_q, pdm_clk_d;
  logic [DEC_W-1:0]     dec_cnt_q, dec_cnt_d;
  logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [CIC_ORDER-1:0] vld_pipe_q, vld_pipe_d;
  logic                 pcm_valid_q, pcm_valid_d;
  pcm_t                 pcm_data_q, pcm_data_d;
  pcm_t                 pcm_a;
  logic                 sample_a, dec_event, warm_done;

  always_comb begin
    sample_a   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    dec_event  = sample_a && (dec_cnt_q == DEC_W'(DEC_RATE - 1));
    warm_done  = (warm_cnt_q == WARM_W'(CIC_ORDER));
    div_cnt_d  = sample_a ? '0 : div_cnt_q + 1'b1;
    pdm_clk_d  = (div_cnt_q >= DIV_W'(CLK_DIV / 2));
    dec_cnt_d  = sample_a ? dec_cnt_q + 1'b1 : dec_cnt_q;
    warm_cnt_d = (dec_event && !warm_done) ? warm_cnt_q + 1'b1 : warm_cnt_q;
    // the first CIC_ORDER events only fill the comb delays, so they never reach the output
    vld_pipe_d  = {vld_pipe_q[CIC_ORDER-2:0], dec_event && warm_done};
    pcm_valid_d = vld_pipe_q[CIC_ORDER-1];
    pcm_data_d  = vld_pipe_q[CIC_ORDER-1] ? pcm_a : pcm_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q   <= '0;
      pdm_clk_q   <= 1'b0;
      dec_cnt_q   <= '0;
      warm_cnt_q  <= '0;
      vld_pipe_q  <= '0;
      pcm_valid_q <= 1'b0;
      pcm_data_q  <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      pdm_clk_q   <= pdm_clk_d;
      dec_cnt_q   <= dec_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      pcm_valid_q <= pcm_valid_d;
      pcm_data_q  <= pcm_data_d;
    end
  end

  cic_channel u_chan_a (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_a),
    .sample_bit (pdm_in),
    .dec_event  (dec_event),
    .pcm_sat    (pcm_a)
  );

`ifdef PDM_STEREO_EN
  logic sample_b;
  pcm_t pcm_b;
  pcm_t pcm_data_b_q, pcm_data_b_d;

  always_comb begin
    sample_b     = (div_cnt_q == DIV_W'(CLK_DIV / 2 - 1));
    pcm_data_b_d = vld_pipe_q[CIC_ORDER-1] ? pcm_b : pcm_data_b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcm_data_b_q <= '0;
    else     pcm_data_b_q <= pcm_data_b_d;
  end

  cic_channel u_chan_b (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_b),
    .sample_bit (pdm_in),
    .dec_event  (dec_event),
    .pcm_sat    (pcm_b)
  );

  assign pcm_data_b = pcm_data_b_q;
`else
  assign pcm_data_b = '0;
`endif

  assign pdm_clk   = pdm_clk_q;
  assign pcm_valid = pcm_valid_q;
  assign pcm_data  = pcm_data_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - randomized self-checking bench against a periodic-pattern CIC model
module tb_pdm_cic_decimator;

  localparam int CLK_DIV   = 32;
  localparam int FIRST_VLD = 8194;
  localparam int VLD_GAP   = 2048;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pdm_in = 1'b0;
  logic               pdm_clk;
  logic               pcm_valid;
  logic signed [18:0] pcm_data;
  logic signed [18:0] pcm_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  pdm_cic_decimator #(.CLK_DIV(CLK_DIV), .DEC_RATE(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .pdm_clk    (pdm_clk),
    .pdm_in     (pdm_in),
    .pcm_data   (pcm_data),
    .pcm_data_b (pcm_data_b),
    .pcm_valid  (pcm_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // steady-state CIC3 R=64 response to a 64-periodic bitstream: 64^2 * sum of +/-1 values, clamped
  function automatic longint model_pcm(input logic [63:0] pat);
    longint s = 0;
    for (int i = 0; i < 64; i++) s += pat[i] ? 1 : -1;
    s = s * 4096;
    if (s > 262143) s = 262143;
    if (s < -262144) s = -262144;
    return s;
  endfunction

  // ends at a falling edge with rst released; next rising edge is cycle 0
  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b1;
    pdm_in = 1'b0;
    #1;
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_valid", pcm_valid, 0);
    check("rst_data", pcm_data, 0);
    check("rst_data_b", pcm_data_b, 0);
    repeat (3) @(negedge clk);
    check("rst_hold_pdm_clk", pdm_clk, 0);
    check("rst_hold_valid", pcm_valid, 0);
    rst = 1'b0;
  endtask

  task automatic run_case(input string name, input logic [63:0] pat, input bit b_fixed,
                          input logic b_val, input int n_val, input int first_chk,
                          input bit chk_b, input int rst_at);
    int     k = 0;
    int     vcount = 0;
    int     m;
    int     rst_pending = rst_at;
    longint exp_a = model_pcm(pat);
    longint exp_b = b_val ? 262143 : -262144;
    int     last_k = FIRST_VLD + (n_val - 1) * VLD_GAP;
    apply_reset();
    while (vcount < n_val && k <= last_k) begin
      m = k % CLK_DIV;
      if (m == CLK_DIV - 1)      pdm_in = pat[(k / CLK_DIV) % 64];
      else if (m == CLK_DIV / 2 - 1) pdm_in = b_fixed ? b_val : 1'($urandom);
      else                       pdm_in = 1'($urandom);
      @(posedge clk);
      #1;
      check({name, "_pdm_clk"}, pdm_clk, (m >= CLK_DIV / 2) ? 1 : 0);
      check({name, "_valid"}, pcm_valid,
            (k >= FIRST_VLD && (k - FIRST_VLD) % VLD_GAP == 0) ? 1 : 0);
      if (k < FIRST_VLD) check({name, "_warm_data"}, pcm_data, 0);
`ifndef PDM_STEREO_EN
      check({name, "_b_zero"}, pcm_data_b, 0);
`endif
      if (pcm_valid) begin
        vcount++;
        if (vcount >= first_chk) check({name, "_pcm"}, pcm_data, exp_a);
`ifdef PDM_STEREO_EN
        if (chk_b) check({name, "_pcm_b"}, pcm_data_b, exp_b);
`else
        if (chk_b) check({name, "_pcm_b_off"}, pcm_data_b, 0);
`endif
      end
      if (k == rst_pending) begin
        apply_reset();
        k = 0;
        vcount = 0;
        rst_pending = -1;
      end else begin
        k++;
        @(negedge clk);
      end
    end
    check({name, "_valid_count"}, vcount, n_val);
  endtask

  initial begin
    logic [63:0] pat;
    run_case("ones", {64{1'b1}}, 1'b1, 1'b0, 4, 1, 1'b1, -1);
    run_case("zeros", 64'h0, 1'b0, 1'b0, 4, 1, 1'b0, -1);
    pat = 64'h5555_5555_5555_5555;
    run_case("alt", pat, 1'b0, 1'b0, 4, 1, 1'b0, -1);
    pat = {$urandom, $urandom};
    run_case("rand", pat, 1'b0, 1'b0, 4, 3, 1'b0, -1);
    pat = {$urandom, $urandom};
    run_case("rand_rst", pat, 1'b0, 1'b0, 4, 3, 1'b0, 5000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
